// File: rtl/reg_file_sb.sv
// reg_file_sb: writeback end of the pipeline. Commits the WB stage's
// destination/result pair into a 32 x 32-bit MIPS register file, serves two
// combinational read ports with same-cycle write-through bypass, and keeps a
// per-register busy scoreboard that drives the decode stall request.
//
// Optional debug port, enabled by defining REGFILE_DBG_PORT_EN:
//   dbg_addr/dbg_data : raw read of stored contents (no bypass, r0 reads 0)
//   dbg_wr_count      : number of committed writes, wraps at 2^32
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              stall
`ifdef REGFILE_DBG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       dbg_wr_count
`endif
);

  localparam int NREG = 1 << ADDR_W;

  // A zero destination index is the only write disable.
  logic wb_en;
  assign wb_en = (wb_rd != '0);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              issue_set;

  // Register storage: commit the writeback result on every edge with a non-zero index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is reset on purpose -- every register must read 0
      // straight out of reset, so this storage maps to flops, not a RAM macro.
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      // NOTE: non-blocking so every read in this edge sees pre-edge state.
      regs_q[wb_rd] <= wb_result;
    end
  end

  // Read port A: register 0 is hardwired, then the bypass, then storage.
  always_comb begin
    // NOTE: default first so no path through the block leaves rs_data unassigned (no latch).
    rs_data = '0;
    if (rs_addr != '0) begin
      rs_data = (rs_addr == wb_rd) ? wb_result : regs_q[rs_addr];
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rt_data = '0;
    if (rt_addr != '0) begin
      rt_data = (rt_addr == wb_rd) ? wb_result : regs_q[rt_addr];
    end
  end

  // Operand readiness: a register being written this cycle is ready via the bypass.
  always_comb begin
    rs_busy = busy_q[rs_addr] && !(wb_en && (wb_rd == rs_addr));
    rt_busy = busy_q[rt_addr] && !(wb_en && (wb_rd == rt_addr));
    stall   = (rs_busy && rs_used) || (rt_busy && rt_used);
  end

  // Scoreboard next state: clear on writeback, then set on issue so a new
  // producer for the same register wins over the retiring one.
  always_comb begin
    issue_set = issue_valid && !stall && (issue_rd != '0);
    busy_d    = busy_q;
    if (wb_en) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef REGFILE_DBG_PORT_EN
  logic [31:0] wr_count_q;
  logic [31:0] wr_count_d;

  // Debug read: stored value only, never the in-flight writeback.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0) begin
      dbg_data = regs_q[dbg_addr];
    end
  end

  // Committed-write counter next state; wraps naturally at 2^32.
  always_comb begin
    wr_count_d = wr_count_q;
    if (wb_en) begin
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  // Committed-write counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign dbg_wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb. A behavioural model of the register
// file and scoreboard produces expected outputs, which are queued when the
// stimulus is driven and popped/compared once the DUT outputs have settled.
// Define REGFILE_DBG_PORT_EN for both bench and RTL to exercise the debug port.
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_result;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          rs_used;
  logic          rt_used;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          rs_busy;
  logic          rt_busy;
  logic          stall;
`ifdef REGFILE_DBG_PORT_EN
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [31:0]   dbg_wr_count;
`endif

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_rd       (wb_rd),
    .wb_result   (wb_result),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_used     (rs_used),
    .rt_used     (rt_used),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .stall       (stall)
`ifdef REGFILE_DBG_PORT_EN
    ,
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .dbg_wr_count(dbg_wr_count)
`endif
  );

  typedef struct {
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          rs_busy;
    logic          rt_busy;
    logic          stall;
    logic [DW-1:0] dbg_data;
    logic [31:0]   dbg_wr_count;
  } exp_t;

  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];
  logic [31:0]   m_wr_count;

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (a == wb_rd) return wb_result;
    return m_regs[a];
  endfunction

  function automatic logic m_busy_out(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
    return m_busy[a] && !(wb_rd == a);
  endfunction

  function automatic logic m_stall();
    return (m_busy_out(rs_addr) && rs_used) || (m_busy_out(rt_addr) && rt_used);
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    e.rs_data      = m_read(rs_addr);
    e.rt_data      = m_read(rt_addr);
    e.rs_busy      = m_busy_out(rs_addr);
    e.rt_busy      = m_busy_out(rt_addr);
    e.stall        = m_stall();
    e.dbg_data     = '0;
    e.dbg_wr_count = m_wr_count;
`ifdef REGFILE_DBG_PORT_EN
    if (dbg_addr != '0) e.dbg_data = m_regs[dbg_addr];
`endif
    return e;
  endfunction

  // Model update at each edge from the inputs presented before the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] <= '0;
        m_busy[i] <= 1'b0;
      end
      m_wr_count <= '0;
    end else begin
      if (wb_rd != '0) begin
        m_regs[wb_rd] <= wb_result;
        m_busy[wb_rd] <= 1'b0;
        m_wr_count    <= m_wr_count + 32'd1;
      end
      if (issue_valid && !m_stall() && issue_rd != '0) begin
        m_busy[issue_rd] <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs, let them settle, queue the model's expectation.
  task automatic apply(input logic [AW-1:0] w_rd, input logic [DW-1:0] w_res,
                       input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic ua, input logic ub,
                       input logic iv, input logic [AW-1:0] ird);
    wb_rd       = w_rd;
    wb_result   = w_res;
    rs_addr     = a;
    rt_addr     = b;
    rs_used     = ua;
    rt_used     = ub;
    issue_valid = iv;
    issue_rd    = ird;
    #2;
    sb_q.push_back(model_expect());
  endtask

  task automatic pop(output exp_t e);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: no expectation queued");
      e = '{default: '0};
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      apply('0, '0, AW'(i), AW'(NR - 1 - i), 1'b1, 1'b1, 1'b0, '0);
      pop(e);
      checks += 5;
      if (rs_data !== e.rs_data || rs_data !== '0) begin
        errors++; $display("FAIL reset_rs_data[%0d]: got %h want %h", i, rs_data, e.rs_data);
      end
      if (rt_data !== e.rt_data || rt_data !== '0) begin
        errors++; $display("FAIL reset_rt_data[%0d]: got %h want %h", i, rt_data, e.rt_data);
      end
      if (rs_busy !== e.rs_busy) begin
        errors++; $display("FAIL reset_rs_busy[%0d]: got %b want %b", i, rs_busy, e.rs_busy);
      end
      if (rt_busy !== e.rt_busy) begin
        errors++; $display("FAIL reset_rt_busy[%0d]: got %b want %b", i, rt_busy, e.rt_busy);
      end
      if (stall !== e.stall) begin
        errors++; $display("FAIL reset_stall[%0d]: got %b want %b", i, stall, e.stall);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    apply(5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, '0);
    pop(e);
    checks++;
    if (rs_data !== e.rs_data) begin
      errors++; $display("FAIL bypass_same_cycle: got %h want %h", rs_data, e.rs_data);
    end
    tick();
    apply('0, 32'h0BADF00D, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, '0);
    pop(e);
    checks += 2;
    if (rs_data !== e.rs_data) begin
      errors++; $display("FAIL bypass_stored_rs: got %h want %h", rs_data, e.rs_data);
    end
    if (rt_data !== e.rt_data) begin
      errors++; $display("FAIL bypass_stored_rt: got %h want %h", rt_data, e.rt_data);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    exp_t e;
    apply('0, 32'h12345678, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0);
    pop(e);
    checks += 2;
    if (rt_data !== e.rt_data) begin
      errors++; $display("FAIL zero_rt_data: got %h want %h", rt_data, e.rt_data);
    end
    if (stall !== e.stall) begin
      errors++; $display("FAIL zero_stall: got %b want %b", stall, e.stall);
    end
    tick();
    apply(5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, '0);
    pop(e);
    checks += 4;
    if (rs_data !== e.rs_data) begin
      errors++; $display("FAIL zero_rs_later: got %h want %h", rs_data, e.rs_data);
    end
    if (rt_data !== e.rt_data) begin
      errors++; $display("FAIL zero_rt_later: got %h want %h", rt_data, e.rt_data);
    end
    if (rs_busy !== e.rs_busy || rt_busy !== e.rt_busy) begin
      errors++; $display("FAIL zero_busy: got %b%b want %b%b", rs_busy, rt_busy, e.rs_busy, e.rt_busy);
    end
    if (stall !== e.stall) begin
      errors++; $display("FAIL zero_stall_later: got %b want %b", stall, e.stall);
    end
    tick();
  endtask

  task automatic test_busy_stall();
    exp_t e;
    apply('0, '0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8);
    pop(e);
    checks++;
    if (rs_busy !== e.rs_busy || stall !== e.stall) begin
      errors++; $display("FAIL busy_issue_cycle: got %b/%b want %b/%b", rs_busy, stall, e.rs_busy, e.stall);
    end
    tick();
    apply('0, '0, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, '0);
    pop(e);
    checks += 3;
    if (rs_busy !== e.rs_busy) begin
      errors++; $display("FAIL busy_next_rs: got %b want %b", rs_busy, e.rs_busy);
    end
    if (rt_busy !== e.rt_busy) begin
      errors++; $display("FAIL busy_next_rt: got %b want %b", rt_busy, e.rt_busy);
    end
    if (stall !== e.stall) begin
      errors++; $display("FAIL busy_next_stall: got %b want %b", stall, e.stall);
    end
    tick();
    apply('0, '0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, '0);
    pop(e);
    checks++;
    if (rt_busy !== e.rt_busy || stall !== e.stall) begin
      errors++; $display("FAIL busy_unused: got %b/%b want %b/%b", rt_busy, stall, e.rt_busy, e.stall);
    end
    tick();
    apply(5'd8, 32'h55, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, '0);
    pop(e);
    checks += 3;
    if (rs_busy !== e.rs_busy) begin
      errors++; $display("FAIL wb_clear_rs_busy: got %b want %b", rs_busy, e.rs_busy);
    end
    if (stall !== e.stall) begin
      errors++; $display("FAIL wb_clear_stall: got %b want %b", stall, e.stall);
    end
    if (rs_data !== e.rs_data) begin
      errors++; $display("FAIL wb_clear_data: got %h want %h", rs_data, e.rs_data);
    end
    tick();
    apply('0, '0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, '0);
    pop(e);
    checks++;
    if (rs_busy !== e.rs_busy || rs_data !== e.rs_data) begin
      errors++; $display("FAIL after_clear: got %b/%h want %b/%h", rs_busy, rs_data, e.rs_busy, e.rs_data);
    end
    tick();
  endtask

  task automatic test_set_clear();
    exp_t e;
    apply('0, '0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    pop(e);
    tick();
    apply(5'd9, 32'h99, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    pop(e);
    checks++;
    if (rs_busy !== e.rs_busy || rs_data !== e.rs_data) begin
      errors++; $display("FAIL setclr_bypass: got %b/%h want %b/%h", rs_busy, rs_data, e.rs_busy, e.rs_data);
    end
    tick();
    apply('0, '0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    pop(e);
    checks++;
    if (rs_busy !== e.rs_busy) begin
      errors++; $display("FAIL set_wins: got %b want %b", rs_busy, e.rs_busy);
    end
    tick();
    apply(5'd9, 32'h999, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12);
    pop(e);
    tick();
    apply('0, '0, 5'd9, 5'd12, 1'b0, 1'b0, 1'b0, '0);
    pop(e);
    checks += 2;
    if (rs_busy !== e.rs_busy) begin
      errors++; $display("FAIL diff_idx_clear: got %b want %b", rs_busy, e.rs_busy);
    end
    if (rt_busy !== e.rt_busy) begin
      errors++; $display("FAIL diff_idx_set: got %b want %b", rt_busy, e.rt_busy);
    end
    tick();
    apply('0, '0, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10);
    pop(e);
    checks++;
    if (stall !== e.stall) begin
      errors++; $display("FAIL stall_block_stall: got %b want %b", stall, e.stall);
    end
    tick();
    apply('0, '0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b0, '0);
    pop(e);
    checks++;
    if (rt_busy !== e.rt_busy) begin
      errors++; $display("FAIL stall_blocks_issue: got %b want %b", rt_busy, e.rt_busy);
    end
    tick();
    apply(5'd12, 32'hC, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    pop(e);
    tick();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply(5'd3, 32'hA5A5A5A5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4);
    pop(e);
    tick();
    apply('0, '0, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, '0);
    pop(e);
    checks++;
    if (rs_data !== e.rs_data || rt_busy !== e.rt_busy || stall !== e.stall) begin
      errors++; $display("FAIL pre_reset: got %h/%b/%b want %h/%b/%b",
                         rs_data, rt_busy, stall, e.rs_data, e.rt_busy, e.stall);
    end
    #1;
    rst = 1'b1;
    #1;
    sb_q.push_back(model_expect());
    pop(e);
    checks += 3;
    if (rs_data !== e.rs_data || rs_data !== '0) begin
      errors++; $display("FAIL mid_reset_data: got %h want %h", rs_data, e.rs_data);
    end
    if (rt_busy !== e.rt_busy || rt_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_busy: got %b want %b", rt_busy, e.rt_busy);
    end
    if (stall !== e.stall) begin
      errors++; $display("FAIL mid_reset_stall: got %b want %b", stall, e.stall);
    end
    tick();
    rst = 1'b0;
    apply(5'd4, 32'h77, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
    pop(e);
    tick();
    apply('0, '0, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, '0);
    pop(e);
    checks += 2;
    if (rs_data !== e.rs_data) begin
      errors++; $display("FAIL post_reset_wb_data: got %h want %h", rs_data, e.rs_data);
    end
    if (rs_busy !== e.rs_busy || stall !== e.stall) begin
      errors++; $display("FAIL post_reset_busy: got %b/%b want %b/%b", rs_busy, stall, e.rs_busy, e.stall);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int n = 0; n < 300; n++) begin
      apply(($urandom_range(0, 1) == 0) ? 5'd0 : AW'($urandom_range(0, NR - 1)),
            DW'($urandom),
            AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)));
      pop(e);
      checks++;
      if (rs_data !== e.rs_data || rt_data !== e.rt_data || rs_busy !== e.rs_busy ||
          rt_busy !== e.rt_busy || stall !== e.stall) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h %h %b%b%b want %h %h %b%b%b", n,
                 rs_data, rt_data, rs_busy, rt_busy, stall,
                 e.rs_data, e.rt_data, e.rs_busy, e.rt_busy, e.stall);
      end
      tick();
    end
  endtask

`ifdef REGFILE_DBG_PORT_EN
  task automatic test_dbg();
    exp_t e;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    apply(5'd1, 32'h11, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    pop(e);
    tick();
    apply(5'd2, 32'h22, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    pop(e);
    tick();
    apply(5'd0, 32'h33, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    pop(e);
    tick();
    dbg_addr = 5'd1;
    apply(5'd1, 32'hFEEDFACE, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    pop(e);
    checks += 3;
    if (dbg_wr_count !== e.dbg_wr_count || dbg_wr_count !== 32'd2) begin
      errors++; $display("FAIL dbg_wr_count: got %0d want %0d", dbg_wr_count, e.dbg_wr_count);
    end
    if (dbg_data !== e.dbg_data || dbg_data !== 32'h11) begin
      errors++; $display("FAIL dbg_no_bypass: got %h want %h", dbg_data, e.dbg_data);
    end
    tick();
    dbg_addr = 5'd0;
    apply('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    pop(e);
    if (dbg_data !== e.dbg_data || dbg_wr_count !== e.dbg_wr_count) begin
      errors++; $display("FAIL dbg_r0: got %h/%0d want %h/%0d", dbg_data, dbg_wr_count,
                         e.dbg_data, e.dbg_wr_count);
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    wb_rd       = '0;
    wb_result   = '0;
    rs_addr     = '0;
    rt_addr     = '0;
    rs_used     = 1'b0;
    rt_used     = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
`ifdef REGFILE_DBG_PORT_EN
    dbg_addr    = '0;
`endif
    #1;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_busy_stall();
    test_set_clear();
    test_reset_mid();
    test_back_to_back();
`ifdef REGFILE_DBG_PORT_EN
    test_dbg();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Receiving end of the writeback interface. Takes the gated destination/result pair from the WB stage and commits it into a 32 x 32-bit MIPS general-purpose register file.
- Provides two combinational read ports for the decode stage, with same-cycle write-through bypass.
- Keeps a per-register busy scoreboard. Decode marks a destination busy at issue; the writeback clears it. Decode gets operand-busy flags and a stall request.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width (2^ADDR_W registers).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- wb_rd  input  5  writeback destination. 0 means no write; WB forces 0 when register_write is low.
- wb_result  input  32  writeback data.
- rs_addr  input  5  read port A index.
- rt_addr  input  5  read port B index.
- rs_used  input  1  decode needs operand A this cycle.
- rt_used  input  1  decode needs operand B this cycle.
- issue_valid  input  1  decode issues an instruction this cycle.
- issue_rd  input  5  destination of the issuing instruction (0 = none).
- rs_data  output  32  operand A.
- rt_data  output  32  operand B.
- rs_busy  output  1  operand A has an outstanding producer.
- rt_busy  output  1  operand B has an outstanding producer.
- stall  output  1  decode must hold this cycle.

Behaviour:
- Reset, asynchronous while rst is high:
  - all 32 registers = 0; all busy bits = 0.
  - Outputs then follow the combinational rules below: data 0, busy 0, stall 0.
- Write:
  - On a rising clk edge with wb_rd != 0, regs[wb_rd] <= wb_result.
  - wb_rd == 0 never writes. There is no separate write-enable; a zero index is the disable.
- Register 0 always reads 0 and is never marked busy.
- Read, combinational:
  - rs_data = 0 if rs_addr == 0.
  - else wb_result if rs_addr == wb_rd (same-cycle bypass).
  - else regs[rs_addr].
  - rt_data follows the same rules with rt_addr.
- Scoreboard: busy[31:1] register, busy[0] tied 0. On each rising edge:
  - set = issue_valid && !stall && issue_rd != 0 → sets busy[issue_rd].
  - clear = wb_rd != 0 → clears busy[wb_rd].
  - Same index set and cleared in the same edge: set wins, because a new producer is in flight. Final bit = 1.
  - Different indices: both take effect.
  - issue_valid while stall = 1: no mark.
- Busy outputs:
  - rs_busy = busy[rs_addr] && !(wb_rd == rs_addr && wb_rd != 0). A register being written this cycle is ready through the bypass.
  - rt_busy follows the same rule with rt_addr.
- stall = (rs_busy && rs_used) || (rt_busy && rt_used). Purely combinational, zero latency.
- Latency:
  - write visible through the bypass in the same cycle, and from storage on the next cycle.
  - a busy set is visible the cycle after issue.
- Reset mid-operation: all contents and busy bits are cleared immediately. In-flight writebacks after reset are committed normally; a clear of an already-clear busy bit is harmless.
- Writeback to a non-busy register, such as an out-of-order or unscored write, is legal: data is written and busy is unchanged (stays 0).

Optional Feature:
- Macro: REGFILE_DBG_PORT_EN.
- Defined:
  - adds ports dbg_addr (input, 5) and dbg_data (output, 32): combinational read of the stored value, no bypass, register 0 reads 0.
  - adds dbg_wr_count (output, 32): counts committed writes (wb_rd != 0), reset to 0, wraps from 0xFFFFFFFF to 0.
- Not defined: these ports and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then read all indices → every read 0, every busy 0, stall 0. Assert rst mid-run after writes → reads return 0 immediately, before any clock edge.
- wb_rd=5, wb_result=0xDEADBEEF, rs_addr=5 in the same cycle → rs_data=0xDEADBEEF before the edge; after the edge with wb_rd=0, still 0xDEADBEEF.
- wb_rd=0, wb_result=0x12345678, rt_addr=0 → rt_data=0; a later read of register 0 = 0; busy stays 0 when issue_rd=0.
- Issue issue_rd=8; next cycle rs_addr=8, rs_used=1 → rs_busy=1, stall=1. A cycle with wb_rd=8, result 0x55 → rs_busy=0, stall=0, rs_data=0x55.
- Same edge issue_rd=9 and wb_rd=9 → busy[9]=1 afterwards. With stall=1, issue_rd=10 → busy[10] stays 0.
- With REGFILE_DBG_PORT_EN: 3 writes to registers 1,2,0 → dbg_wr_count=2. dbg_addr=1 returns the stored value with no bypass while wb_rd=1 presents new data.
